// File: rtl/z0_stream_pkg.sv
// Shared state type and default sizes for the z0 stream deserializer.
// Defining PARITY_CHECK_EN adds the PARITY state to the decoder.
package z0_stream_pkg;

   localparam int Z0_DATA_W_DEF     = 8;
   localparam int Z0_FIFO_DEPTH_DEF = 4;

`ifdef PARITY_CHECK_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } z0_state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_STOP   = 2'd3
   } z0_state_e;
`endif

endpackage

// File: rtl/z0_byte_fifo.sv
// First-word-fall-through payload FIFO; push while full is accepted only
// when a pop frees the head slot in the same cycle.
module z0_byte_fifo
   import z0_stream_pkg::*;
#(
   parameter int DATA_W     = Z0_DATA_W_DEF,
   parameter int FIFO_DEPTH = Z0_FIFO_DEPTH_DEF
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic                          pop,
   output logic [DATA_W-1:0]             head,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(FIFO_DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Head is forced to zero when empty so the output never exposes stale entries.
   assign head = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/z0_stream_deserializer.sv
// Serial frame decoder (start, DATA_W bits LSB first, [parity], stop) feeding a
// payload FIFO. Optional even-parity check is enabled with PARITY_CHECK_EN.
module z0_stream_deserializer
   import z0_stream_pkg::*;
#(
   parameter int DATA_W     = Z0_DATA_W_DEF,
   parameter int FIFO_DEPTH = Z0_FIFO_DEPTH_DEF
) (
   input  logic                          my_clk,
   input  logic                          global_reset,
   input  logic                          z0_in,
   input  logic                          bit_valid,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          err_frame,
   output logic                          err_overflow
);

   localparam int CNT_W = $clog2(DATA_W);

   z0_state_e         state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              stop_smp;
   logic              frame_good;
   logic              frame_bad;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              frame_drop;

`ifdef PARITY_CHECK_EN
   logic              par_err;
`endif

   assign stop_smp = bit_valid & (state == ST_STOP);

`ifdef PARITY_CHECK_EN
   assign frame_good = stop_smp & z0_in & ~par_err;
   assign frame_bad  = stop_smp & (~z0_in | par_err);
`else
   assign frame_good = stop_smp & z0_in;
   assign frame_bad  = stop_smp & ~z0_in;
`endif

   assign out_valid  = ~fifo_empty;
   assign fifo_pop   = out_ready & ~fifo_empty;
   assign frame_drop = frame_good & fifo_full & ~fifo_pop;

   always_ff @(posedge my_clk or negedge global_reset) begin
      if (!global_reset) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         err_frame    <= 1'b0;
         err_overflow <= 1'b0;
`ifdef PARITY_CHECK_EN
         par_err      <= 1'b0;
`endif
      end else begin
         err_frame    <= frame_bad;
         err_overflow <= frame_drop;
         if (bit_valid) begin
            case (state)
               ST_IDLE: begin
                  if (!z0_in) begin
                     state   <= ST_DATA;
                     bit_cnt <= '0;
                  end
               end
               ST_DATA: begin
                  shreg[bit_cnt] <= z0_in;
                  if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                     bit_cnt <= '0;
`ifdef PARITY_CHECK_EN
                     state   <= ST_PARITY;
`else
                     state   <= ST_STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
`ifdef PARITY_CHECK_EN
               // Even parity: data ones plus the parity bit must be even.
               ST_PARITY: begin
                  par_err <= (^shreg) ^ z0_in;
                  state   <= ST_STOP;
               end
`endif
               ST_STOP: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   z0_byte_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (my_clk),
      .rst_n     (global_reset),
      .push      (frame_good),
      .push_data (shreg),
      .pop       (fifo_pop),
      .head      (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: doc/z0_stream_deserializer.md
Z0_STREAM_DESERIALIZER -- requirements
Module: z0_stream_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload bits per frame (4..16).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte FIFO entries (power of two, >=2).
REQ-003 SHALL have port my_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port global_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port z0_in  input  1  serial line from the HelloWorld z0 output; idle level 1.
REQ-006 SHALL have port bit_valid  input  1  sample strobe; z0_in is sampled only in cycles where bit_valid=1.
REQ-007 SHALL have port out_data  output  DATA_W  head-of-FIFO payload.
REQ-008 SHALL have port out_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid&out_ready.
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-011 SHALL have port err_frame  output  1  one-cycle pulse on bad stop bit.
REQ-012 SHALL have port err_overflow  output  1  one-cycle pulse when a good frame is dropped because the FIFO is full.

Function
REQ-013 SHALL implement FSM IDLE, DATA, PARITY, STOP; transitions occur only on bit_valid=1 cycles.
REQ-014 IDLE: sampled 0 = start bit -> DATA with bit counter 0; sampled 1 -> stay.
REQ-015 DATA: shift sample into bit position counter (LSB first); after bit DATA_W-1 -> PARITY if PARITY_CHECK_EN is defined, else -> STOP.
REQ-016 STOP: sampled 1 = good frame -> push payload; sampled 0 -> pulse err_frame, discard payload; both cases -> IDLE.
REQ-017 A pushed byte SHALL appear at out_data with out_valid=1 in the cycle after the stop-bit sample (1-cycle latency, first-word-fall-through).
REQ-018 Pop SHALL occur when out_valid&out_ready; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 Push while full without a same-cycle pop SHALL drop the byte, pulse err_overflow, and leave FIFO contents unchanged.
REQ-020 Push and pop in the same cycle SHALL both succeed, including when full; fifo_count is unchanged.
REQ-021 Pop while empty SHALL be ignored.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL range 0..FIFO_DEPTH.
REQ-023 bit_valid=0 cycles SHALL hold FSM, bit counter and shift register unchanged.

Reset
REQ-024 global_reset=0 SHALL immediately force FSM=IDLE, bit counter=0, shift register=0, FIFO pointers=0, fifo_count=0, out_valid=0, out_data=0, err_frame=0, err_overflow=0.
REQ-025 Reset mid-frame SHALL discard the partial frame; after release, decoding SHALL restart at IDLE awaiting a start bit.
REQ-026 Reset deassertion SHALL take effect at the next rising edge of my_clk with no spurious err pulses.

Configuration
REQ-027 Macro PARITY_CHECK_EN SHALL, when defined, add state PARITY sampling one even-parity bit after the data bits; mismatch -> frame discarded, err_frame pulsed at the stop-bit sample, stop bit still consumed.
REQ-028 Without PARITY_CHECK_EN, frame = start + DATA_W data + stop, and no PARITY state or parity logic SHALL exist.

Structure
REQ-029 A shared package z0_stream_pkg SHALL hold the FSM state enum typedef and the default DATA_W/FIFO_DEPTH constants.
REQ-030 The FIFO SHALL be a sub-module z0_byte_fifo (parameters DATA_W, FIFO_DEPTH; push/pop/full/empty/count); FSM and shift logic stay in the top.

Verification
REQ-031 bit_valid always 1, z0_in sends start,0xA5 LSB first,stop=1 -> out_data=0xA5, out_valid=1 one cycle after stop sample, fifo_count=1.
REQ-032 Frame 0x3C with stop=0 -> err_frame pulses for 1 cycle, out_valid stays 0, FSM returns to IDLE.
REQ-033 out_ready=0, send 5 good frames 0x01..0x05 (FIFO_DEPTH=4) -> FIFO holds 0x01..0x04, err_overflow pulses once at the 5th stop bit, fifo_count=4.
REQ-034 FIFO full, out_ready=1 in the same cycle as the next good stop bit 0x06 -> 0x01 popped, 0x06 pushed, fifo_count stays 4, no err_overflow.
REQ-035 Assert global_reset=0 after 4 data bits of a frame, then release and send 0x5A -> only 0x5A is output, all outputs 0 during reset.
REQ-036 With PARITY_CHECK_EN, 0x07 sent with parity bit 0 -> err_frame, no push; resent with parity bit 1 -> out_data=0x07.
